// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, FSM state encoding and IR field positions shared by the control unit.
package cpu_pkg;
  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;
  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  function automatic logic is_alu(input logic [4:0] op);
    return op >= OP_ADD && op <= OP_ROL;
  endfunction
  function automatic logic is_muldiv(input logic [4:0] op);
    return op == OP_MUL || op == OP_DIV;
  endfunction
endpackage

// File: rtl/reg_select.sv
// reg_select: 4-to-16 one-hot register select, all zero when not enabled.
module reg_select (
  input  logic [3:0]  sel,
  input  logic        en,
  output logic [15:0] onehot
);
  assign onehot = en ? 16'(1) << sel : '0;
endmodule

// File: rtl/control_unit.sv
// control_unit: Moore fetch/decode/execute sequencer driving the datapath enables.
module control_unit
  import cpu_pkg::*;
(
  input  logic        Clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  output logic        PCout,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic        Read,
  output logic        IncPC,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic [4:0]  alu_op,
  output logic        halted,
  output logic        illegal
);
  state_t state;
  logic ill;
  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic alu, md;
  logic unused_ir;
  assign op = ir[OP_HI:OP_LO];
  assign ra = ir[RA_HI:RA_LO];
  assign rb = ir[RB_HI:RB_LO];
  assign rc = ir[RC_HI:RC_LO];
  assign unused_ir = ^ir[RC_LO-1:0];
  assign alu = is_alu(op);
  assign md = is_muldiv(op);
  always_ff @(posedge Clock or posedge clear)
    if (clear) begin
      state <= IDLE;
      ill <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= run ? T0 : IDLE;
        T0: state <= T1;
        T1: state <= T2;
        T2: state <= T3;
        T3:
          if (alu || md) state <= T4;
          else if (op == OP_NOP) state <= run ? T0 : IDLE;
          else begin
            state <= HALT;
            ill <= op != OP_HALT;
          end
        T4: state <= T5;
        T5: state <= md ? T6 : (run ? T0 : IDLE);
        T6: state <= run ? T0 : IDLE;
        default: state <= HALT;
      endcase
    end
  assign PCout    = state == T0;
  assign MARin    = state == T0;
  assign IncPC    = state == T0;
  assign Zin      = state == T0 || state == T4;
  assign Zlowout  = state == T1 || state == T5;
  assign PCin     = state == T1;
  assign Read     = state == T1;
  assign MDRin    = state == T1;
  assign MDRout   = state == T2;
  assign IRin     = state == T2;
  assign Yin      = state == T3 && (alu || md);
  assign LOin     = state == T5 && md;
  assign Zhighout = state == T6;
  assign HIin     = state == T6;
  assign alu_op   = state == T4 ? op : 5'b00000;
  assign halted   = state == HALT;
  assign illegal  = state == HALT && ill;
  // T3 drives Rb into Y, T4 drives Rc; only ALU results write back to Ra in T5
  reg_select u_rin (
    .sel    (ra),
    .en     (state == T5 && alu),
    .onehot (Rin)
  );
  reg_select u_rout (
    .sel    (state == T3 ? rb : rc),
    .en     ((state == T3 && (alu || md)) || state == T4),
    .onehot (Rout)
  );
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table-driven cycle vectors plus directed halt/clear/run-drop sequences.
module tb_control_unit;
  logic Clock = 1'b0, clear = 1'b1, run = 1'b0;
  logic [31:0] ir = '0;
  logic PCout, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin, Read, IncPC;
  logic [15:0] Rin, Rout;
  logic [4:0] alu_op;
  logic halted, illegal;
  logic [52:0] obs;
  int checks = 0, errors = 0;
  localparam logic [13:0] PCO = 14'h2000, PCI = 14'h1000, MAI = 14'h0800, MDI = 14'h0400,
    MDO = 14'h0200, IRI = 14'h0100, YI = 14'h0080, ZI = 14'h0040, ZLO = 14'h0020,
    ZHO = 14'h0010, HII = 14'h0008, LOI = 14'h0004, RD = 14'h0002, INC = 14'h0001;
  localparam logic [31:0] IR_AND = 32'h28918000;
  localparam logic [31:0] IR_MUL = {5'b01111, 4'd4, 4'd5, 4'd6, 15'd0};
  localparam logic [31:0] IR_NOP = {5'b11010, 27'd0};
  localparam logic [31:0] IR_HLT = {5'b11011, 27'd0};
  localparam logic [31:0] IR_BAD = {5'b11111, 27'd0};
  localparam logic [13:0] F0 = PCO | MAI | INC | ZI;
  localparam logic [13:0] F1 = ZLO | PCI | RD | MDI;
  localparam logic [13:0] F2 = MDO | IRI;
  typedef struct {
    logic run;
    logic [31:0] ir;
    logic [52:0] exp;
  } vec_t;
  vec_t v[$];
  control_unit dut (
    .Clock(Clock), .clear(clear), .run(run), .ir(ir),
    .PCout(PCout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .HIin(HIin), .LOin(LOin), .Read(Read), .IncPC(IncPC), .Rin(Rin), .Rout(Rout),
    .alu_op(alu_op), .halted(halted), .illegal(illegal)
  );
  assign obs = {PCout, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout,
                HIin, LOin, Read, IncPC, Rin, Rout, alu_op, halted, illegal};
  always #5 Clock = ~Clock;
  function automatic logic [52:0] ex(input logic [13:0] c, input logic [15:0] ri, input logic [15:0] ro,
                                     input logic [4:0] a, input logic h, input logic il);
    return {c, ri, ro, a, h, il};
  endfunction
  task automatic add(input logic r, input logic [31:0] i, input logic [52:0] e);
    vec_t t;
    t.run = r;
    t.ir = i;
    t.exp = e;
    v.push_back(t);
  endtask
  task automatic chk(input string nm, input logic [52:0] e);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, obs, e);
    end
  endtask
  task automatic step;
    @(posedge Clock);
    @(negedge Clock);
    #1;
  endtask
  task automatic do_reset;
    @(negedge Clock);
    clear = 1'b1;
    run = 1'b0;
    #1 chk("reset_zero", '0);
    @(negedge Clock);
    clear = 1'b0;
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    add(0, IR_AND, '0);
    add(1, IR_AND, '0);
    add(1, IR_AND, ex(F0, 0, 0, 0, 0, 0));
    add(1, IR_AND, ex(F1, 0, 0, 0, 0, 0));
    add(1, IR_AND, ex(F2, 0, 0, 0, 0, 0));
    add(1, IR_AND, ex(YI, 0, 16'h0004, 0, 0, 0));
    add(1, IR_AND, ex(ZI, 0, 16'h0008, 5'b00101, 0, 0));
    add(1, IR_AND, ex(ZLO, 16'h0002, 0, 0, 0, 0));
    add(1, IR_MUL, ex(F0, 0, 0, 0, 0, 0));
    add(1, IR_MUL, ex(F1, 0, 0, 0, 0, 0));
    add(1, IR_MUL, ex(F2, 0, 0, 0, 0, 0));
    add(1, IR_MUL, ex(YI, 0, 16'h0020, 0, 0, 0));
    add(1, IR_MUL, ex(ZI, 0, 16'h0040, 5'b01111, 0, 0));
    add(1, IR_MUL, ex(ZLO | LOI, 0, 0, 0, 0, 0));
    add(0, IR_MUL, ex(ZHO | HII, 0, 0, 0, 0, 0));
    add(0, IR_NOP, '0);
    add(1, IR_NOP, '0);
    add(1, IR_NOP, ex(F0, 0, 0, 0, 0, 0));
    add(1, IR_NOP, ex(F1, 0, 0, 0, 0, 0));
    add(1, IR_NOP, ex(F2, 0, 0, 0, 0, 0));
    add(1, IR_NOP, '0);
    add(1, IR_NOP, ex(F0, 0, 0, 0, 0, 0));
    #1 chk("reset_initial", '0);
    @(negedge Clock);
    clear = 1'b0;
    foreach (v[k]) begin
      run = v[k].run;
      ir = v[k].ir;
      #1 chk($sformatf("vec%0d", k), v[k].exp);
      @(posedge Clock);
      @(negedge Clock);
    end
    do_reset();
    ir = IR_HLT;
    run = 1'b1;
    repeat (4) step();
    chk("halt_t3", '0);
    step();
    chk("halt_enter", ex(0, 0, 0, 0, 1, 0));
    for (int n = 0; n < 20; n++) begin
      step();
      chk($sformatf("halt_hold%0d", n), ex(0, 0, 0, 0, 1, 0));
    end
    do_reset();
    ir = IR_BAD;
    run = 1'b1;
    repeat (5) step();
    chk("illegal_enter", ex(0, 0, 0, 0, 1, 1));
    step();
    chk("illegal_hold", ex(0, 0, 0, 0, 1, 1));
    #2 clear = 1'b1;
    #1 chk("illegal_clear", '0);
    @(negedge Clock);
    clear = 1'b0;
    ir = IR_AND;
    run = 1'b1;
    #1 chk("after_clear_idle", '0);
    repeat (5) step();
    chk("mid_t4", ex(ZI, 0, 16'h0008, 5'b00101, 0, 0));
    #2 clear = 1'b1;
    #1 chk("clear_async_t4", '0);
    @(posedge Clock);
    #1 chk("clear_held", '0);
    @(negedge Clock);
    clear = 1'b0;
    #1 chk("clear_released_idle", '0);
    step();
    chk("clear_first_t0", ex(F0, 0, 0, 0, 0, 0));
    do_reset();
    ir = IR_AND;
    run = 1'b1;
    repeat (3) step();
    chk("drop_t2", ex(F2, 0, 0, 0, 0, 0));
    run = 1'b0;
    step();
    chk("drop_t3", ex(YI, 0, 16'h0004, 0, 0, 0));
    step();
    chk("drop_t4", ex(ZI, 0, 16'h0008, 5'b00101, 0, 0));
    step();
    chk("drop_t5", ex(ZLO, 16'h0002, 0, 0, 0, 0));
    step();
    chk("drop_idle0", '0);
    step();
    chk("drop_idle1", '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port Clock, input, 1, the single system clock; all state changes occur on its rising edge.
REQ-002 SHALL have port clear, input, 1, reset; asynchronous, active-high.
REQ-003 SHALL have port run, input, 1, high permits fetch of the next instruction.
REQ-004 SHALL have port ir, input, 32, datapath IR contents: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
REQ-005 SHALL have the following outputs, each 1 bit, each the datapath enable of the same name: PCout, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin, Read, IncPC.
REQ-006 SHALL have port Rin, output, 16, one-hot register load select for R0..R15.
REQ-007 SHALL have port Rout, output, 16, one-hot register drive select for R0..R15.
REQ-008 SHALL have port alu_op, output, 5, ALU operation code; 5'b00000 when no ALU op is active.
REQ-009 SHALL have port halted, output, 1, high while in HALT.
REQ-010 SHALL have port illegal, output, 1, high in HALT when HALT was entered by an undefined opcode.

Function
REQ-011 SHALL be a Moore FSM with states IDLE, T0, T1, T2, T3, T4, T5, T6 and HALT; outputs SHALL be decoded from the state register and ir only.
REQ-012 SHALL drive every output not named for the current state to 0.
REQ-013 IDLE: all controls 0; SHALL go to T0 if run=1, else stay in IDLE.
REQ-014 T0: PCout, MARin, IncPC and Zin SHALL be 1; next state T1.
REQ-015 T1: Zlowout, PCin, Read and MDRin SHALL be 1; next state T2.
REQ-016 T2: MDRout and IRin SHALL be 1; next state T3.
REQ-017 T3 decode: for opcodes 00011..01011 (add, sub, and, or, shr, shra, shl, ror, rol), 01111 (mul) and 10000 (div), Rout SHALL be one-hot(Rb) and Yin SHALL be 1; next state T4.
REQ-018 T3: opcode 11010 (nop) SHALL assert no controls; next state IDLE/T0 per REQ-023.
REQ-019 T3: opcode 11011 (halt) SHALL go to HALT with illegal=0; any other opcode SHALL go to HALT with illegal=1.
REQ-020 T4: Rout SHALL be one-hot(Rc), alu_op SHALL equal ir[31:27] and Zin SHALL be 1; next state T5.
REQ-021 T5: Zlowout SHALL be 1. For ALU opcodes, Rin SHALL be one-hot(Ra), then proceed per REQ-023. For mul/div, LOin SHALL be 1 and the next state SHALL be T6.
REQ-022 T6 (mul/div only): Zhighout and HIin SHALL be 1; then proceed per REQ-023.
REQ-023 At instruction end the next state SHALL be T0 if run=1, else IDLE; run SHALL be sampled only at instruction end and in IDLE.
REQ-024 Instruction latency SHALL be: ALU 6 cycles, mul/div 7 cycles, nop 4 cycles, all counted from T0.
REQ-025 HALT: all controls 0 and halted=1; SHALL remain in HALT regardless of run until clear.
REQ-026 Rin and Rout SHALL never have more than one bit set, and SHALL never both be non-zero in the same state.

Reset
REQ-027 clear=1 SHALL force state IDLE immediately, without waiting for Clock, including mid-instruction.
REQ-028 During reset all outputs SHALL be 0, including halted and illegal.
REQ-029 The first transition after clear falls SHALL occur on the next Clock rising edge, per REQ-013.

Structure
REQ-030 Opcode constants, the state encoding and field bit positions SHALL reside in shared package cpu_pkg.
REQ-031 A single sub-module reg_select SHALL implement the 4-to-16 one-hot decoder and SHALL be instantiated for the Rin and Rout selects.

Verification
REQ-032 Scenario: run=1, ir=32'h28918000 -> T0..T5 in 6 cycles; T3 Rout=16'h0004, Yin=1; T4 Rout=16'h0008, alu_op=5'b00101, Zin=1; T5 Rin=16'h0002, Zlowout=1; then T0.
REQ-033 Scenario: ir opcode 01111 with Ra=4, Rb=5, Rc=6 -> T5 LOin=1, Zlowout=1, Rin=0; T6 HIin=1, Zhighout=1; returns to T0 after 7 cycles.
REQ-034 Scenario: ir opcode 11011 -> HALT after T3 with halted=1 and illegal=0; HALT held for 20 cycles with run=1.
REQ-035 Scenario: ir opcode 11111 -> HALT with halted=1 and illegal=1.
REQ-036 Scenario: clear pulsed mid-T4 -> all outputs 0 within the same cycle and state IDLE; with run=1, T0 follows on the first edge after clear falls.
REQ-037 Scenario: run dropped during T2 of an ALU instruction -> the instruction completes through T5, then the FSM holds IDLE with IncPC=0.
